// File: rtl/mem1_stage.sv
// EX/MEM1 pipeline register with SRAM load-data capture and load alignment.
// Drives the writeback bus and the decode forwarding bus combinationally from the register.
module mem1_stage #(
  parameter int EX2MEM1_WD = 182,
  parameter int MEM12WB_WD = 166,
  parameter int MEM12ID_WD = 70
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [5:0]            stall,
  input  logic [EX2MEM1_WD-1:0] ex2mem1_bus,
  input  logic [63:0]           data_sram_rdata,
  output logic [MEM12WB_WD-1:0] mem12wb_bus,
  output logic [MEM12ID_WD-1:0] mem12id_fwd
);

  logic [EX2MEM1_WD-1:0] r;
  logic [63:0]           rbuf;
  logic                  rbuf_v;
  logic                  hold;
  logic                  bubble;

  logic [6:0]  lsu_op;
  logic [7:0]  data_ram_sel;
  logic        sel_load;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] ex_result;
  logic [63:0] pc;
  logic [31:0] inst;

  logic [63:0] raw;
  logic [2:0]  off;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_w;
  logic [63:0] load_data;
  logic [63:0] rf_wdata;

  assign hold   = stall[4] & stall[5] & ~flush;
  assign bubble = stall[4] & ~stall[5];

  always_ff @(posedge clk) begin
    if (rst) begin
      r <= '0;
    end else if (flush) begin
      r <= '0;
    end else if (bubble) begin
      r <= '0;
    end else if (!stall[4]) begin
      r <= ex2mem1_bus;
    end
  end

  // SRAM data is only valid in the first MEM1 cycle, so grab it the first time we hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      rbuf   <= '0;
      rbuf_v <= 1'b0;
    end else if (!hold) begin
      rbuf_v <= 1'b0;
    end else if (!rbuf_v) begin
      rbuf   <= data_sram_rdata;
      rbuf_v <= 1'b1;
    end
  end

  assign {lsu_op, data_ram_sel, sel_load, rf_we, rf_waddr, ex_result, pc, inst} = r;

  assign raw  = rbuf_v ? rbuf : data_sram_rdata;
  assign off  = ex_result[2:0];
  assign ld_b = 8'(raw >> {off, 3'b000});
  assign ld_h = 16'(raw >> {off[2:1], 4'b0000});
  assign ld_w = 32'(raw >> {off[2], 5'b00000});

  always_comb begin
    load_data = '0;
    case (lsu_op)
      7'b100_0000: load_data = {{56{ld_b[7]}}, ld_b};
      7'b010_0000: load_data = {{48{ld_h[15]}}, ld_h};
      7'b001_0000: load_data = {{32{ld_w[31]}}, ld_w};
      7'b000_1000: load_data = raw;
      7'b000_0100: load_data = {56'd0, ld_b};
      7'b000_0010: load_data = {48'd0, ld_h};
      7'b000_0001: load_data = {32'd0, ld_w};
      default:     load_data = '0;
    endcase
  end

  assign rf_wdata    = sel_load ? load_data : ex_result;
  assign mem12wb_bus = {rf_we, rf_waddr, rf_wdata, pc, inst};
  assign mem12id_fwd = {rf_we, rf_waddr, rf_wdata};

  // Byte-lane select and the other stages' stall bits are not needed here.
  logic unused_ok;
  assign unused_ok = ^{data_ram_sel, stall[3:0]};

endmodule

// File: tb/tb_mem1_stage.sv
// Randomized and directed bench for mem1_stage against a byte-lane load model.
// The model tracks the instruction in MEM1 and the SRAM word seen in its first cycle there.
module tb_mem1_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [5:0]   stall;
  logic [181:0] ex2mem1_bus;
  logic [63:0]  data_sram_rdata;
  logic [165:0] mem12wb_bus;
  logic [69:0]  mem12id_fwd;

  int checks = 0;
  int errors = 0;

  mem1_stage dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .stall           (stall),
    .ex2mem1_bus     (ex2mem1_bus),
    .data_sram_rdata (data_sram_rdata),
    .mem12wb_bus     (mem12wb_bus),
    .mem12id_fwd     (mem12id_fwd)
  );

  always #5 clk = ~clk;

  // model state: instruction in MEM1, how long it has been there, first-cycle SRAM word
  logic [181:0] m_bus   = '0;
  int           m_age   = 0;
  logic [63:0]  m_data  = '0;
  bit           m_known = 0;

  task automatic chk(input string tag, input logic [165:0] got, input logic [165:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_load(input logic [6:0] op, input logic [2:0] off,
                                           input logic [63:0] d);
    int nb;
    bit sgn;
    int lane;
    logic [63:0] v;
    logic [63:0] mask;
    nb = 0;
    sgn = 0;
    case (op)
      7'h40: begin nb = 1; sgn = 1; end
      7'h20: begin nb = 2; sgn = 1; end
      7'h10: begin nb = 4; sgn = 1; end
      7'h08: begin nb = 8; sgn = 0; end
      7'h04: begin nb = 1; sgn = 0; end
      7'h02: begin nb = 2; sgn = 0; end
      7'h01: begin nb = 4; sgn = 0; end
      default: nb = 0;
    endcase
    if (nb == 0) return 64'd0;
    lane = (int'(off) / nb) * nb;
    v = d >> (8 * lane);
    if (nb < 8) begin
      mask = (64'd1 << (8 * nb)) - 64'd1;
      v = v & mask;
      if (sgn && v[8*nb-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic logic [181:0] mk(input logic [6:0] op, input logic sel, input logic we,
                                      input logic [4:0] wa, input logic [63:0] ex);
    logic [63:0] pc;
    logic [31:0] inst;
    logic [7:0]  sel_b;
    pc    = {$urandom, $urandom};
    inst  = $urandom;
    sel_b = 8'($urandom);
    return {op, sel_b, sel, we, wa, ex, pc, inst};
  endfunction

  function automatic logic [63:0] exp_wdata();
    logic [63:0] raw;
    raw = (m_age == 0) ? data_sram_rdata : m_data;
    if (m_bus[166]) return ref_load(m_bus[181:175], m_bus[98:96], raw);
    return m_bus[159:96];
  endfunction

  task automatic cyc(input logic [181:0] b, input logic [5:0] st, input logic fl,
                     input logic rs, input logic [63:0] rd);
    logic [63:0] w;
    ex2mem1_bus     = b;
    stall           = st;
    flush           = fl;
    rst             = rs;
    data_sram_rdata = rd;
    #1;
    if (m_known) begin
      w = exp_wdata();
      chk("wb_bus", mem12wb_bus, {m_bus[165], m_bus[164:160], w, m_bus[95:0]});
      chk("id_fwd", {96'd0, mem12id_fwd}, {96'd0, m_bus[165], m_bus[164:160], w});
    end
  endtask

  task automatic adv();
    if (rst || flush || (stall[4] && !stall[5])) begin
      m_bus = '0;
      m_age = 0;
      if (rst) m_known = 1;
    end else if (!stall[4]) begin
      m_bus = ex2mem1_bus;
      m_age = 0;
    end else begin
      if (m_age == 0) m_data = data_sram_rdata;
      m_age++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  localparam logic [6:0] LB = 7'h40, LH = 7'h20, LW = 7'h10, LD = 7'h08;
  localparam logic [6:0] LBU = 7'h04, LWU = 7'h01;
  localparam logic [5:0] GO = 6'b000000, HOLD = 6'b110000, BUB = 6'b010000;

  logic [181:0] b;
  logic [63:0]  rd;

  initial begin
    @(negedge clk);
    // reset with random inputs
    cyc(mk(7'($urandom), 1'b1, 1'b1, 5'd3, rnd64()), 6'($urandom), 1'b0, 1'b1, rnd64());
    adv();
    cyc(mk(LD, 1'b1, 1'b1, 5'd3, rnd64()), GO, 1'b0, 1'b1, rnd64());
    chk("rst_wb", mem12wb_bus, '0);
    chk("rst_fwd", {96'd0, mem12id_fwd}, '0);
    adv();

    // byte loads at offset 3
    cyc(mk(LB, 1'b1, 1'b1, 5'd1, 64'h100_0003), GO, 1'b0, 1'b0, rnd64());
    adv();
    cyc(mk(LBU, 1'b1, 1'b1, 5'd1, 64'h100_0003), GO, 1'b0, 1'b0, 64'h0000_0000_8000_0000);
    chk("lb", mem12wb_bus[159:96], 64'hFFFF_FFFF_FFFF_FF80);
    adv();
    cyc(mk(LW, 1'b1, 1'b1, 5'd2, 64'h200_0004), GO, 1'b0, 1'b0, 64'h0000_0000_8000_0000);
    chk("lbu", mem12wb_bus[159:96], 64'h0000_0000_0000_0080);
    adv();

    // word and double loads
    cyc(mk(LWU, 1'b1, 1'b1, 5'd2, 64'h200_0004), GO, 1'b0, 1'b0, 64'h8765_4321_0000_0000);
    chk("lw", mem12wb_bus[159:96], 64'hFFFF_FFFF_8765_4321);
    adv();
    cyc(mk(LD, 1'b1, 1'b1, 5'd2, 64'h200_0000), GO, 1'b0, 1'b0, 64'h8765_4321_0000_0000);
    chk("lwu", mem12wb_bus[159:96], 64'h0000_0000_8765_4321);
    adv();
    rd = rnd64();
    cyc(mk(LH, 1'b1, 1'b1, 5'd4, 64'h300_0002), GO, 1'b0, 1'b0, rd);
    chk("ld", mem12wb_bus[159:96], rd);
    adv();

    // halfword held across a stall while SRAM data wanders
    b = mk(LD, 1'b1, 1'b1, 5'd6, 64'h400_0000);
    cyc(b, HOLD, 1'b0, 1'b0, 64'h0000_0000_ABCD_0000);
    chk("lh_first", mem12wb_bus[159:96], 64'hFFFF_FFFF_FFFF_ABCD);
    adv();
    for (int i = 0; i < 3; i++) begin
      cyc(b, HOLD, 1'b0, 1'b0, rnd64());
      chk("lh_hold", mem12wb_bus[159:96], 64'hFFFF_FFFF_FFFF_ABCD);
      adv();
    end
    cyc(b, GO, 1'b0, 1'b0, rnd64());
    chk("lh_release", mem12wb_bus[159:96], 64'hFFFF_FFFF_FFFF_ABCD);
    adv();
    rd = rnd64();
    cyc(mk(7'd0, 1'b0, 1'b1, 5'd7, 64'h55), BUB, 1'b0, 1'b0, rd);
    chk("after_hold_live", mem12wb_bus[159:96], rd);
    adv();

    // bubble inserted
    cyc(mk(7'd0, 1'b0, 1'b1, 5'd7, 64'h55), GO, 1'b0, 1'b0, rnd64());
    chk("bubble_we", {165'd0, mem12wb_bus[165]}, '0);
    chk("bubble_bus", mem12wb_bus, '0);
    adv();

    // flush while holding a captured load
    cyc(mk(7'd0, 1'b0, 1'b0, 5'd0, 64'd0), HOLD, 1'b0, 1'b0, rnd64());
    adv();
    cyc(mk(7'd0, 1'b0, 1'b0, 5'd0, 64'd0), HOLD, 1'b0, 1'b0, rnd64());
    adv();
    cyc(mk(LB, 1'b1, 1'b1, 5'd9, 64'h7), HOLD, 1'b1, 1'b0, rnd64());
    adv();
    cyc(mk(LD, 1'b1, 1'b1, 5'd10, 64'h8), GO, 1'b0, 1'b0, rnd64());
    chk("flush_bus", mem12wb_bus, '0);
    adv();
    rd = rnd64();
    cyc(mk(LD, 1'b1, 1'b1, 5'd10, 64'h8), HOLD, 1'b0, 1'b0, rd);
    chk("post_flush_live", mem12wb_bus[159:96], rd);
    adv();

    // reset in the middle of a hold
    cyc(mk(LD, 1'b1, 1'b1, 5'd10, 64'h8), HOLD, 1'b0, 1'b1, rnd64());
    adv();
    cyc(mk(LD, 1'b1, 1'b1, 5'd10, 64'h8), HOLD, 1'b0, 1'b0, rnd64());
    chk("rst_hold_bus", mem12wb_bus, '0);
    adv();

    // non-load passthrough
    cyc(mk(7'd0, 1'b0, 1'b1, 5'd5, 64'h1234), GO, 1'b0, 1'b0, rnd64());
    adv();
    cyc(mk(7'd0, 1'b0, 1'b0, 5'd0, 64'd0), GO, 1'b0, 1'b0, rnd64());
    chk("pass_fwd", {96'd0, mem12id_fwd}, {96'd0, 1'b1, 5'd5, 64'h1234});
    adv();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [6:0] op;
      logic [5:0] st;
      int sr;
      op = ($urandom_range(0, 7) == 7) ? 7'd0 : 7'(1 << $urandom_range(0, 6));
      sr = $urandom_range(0, 9);
      st = 6'($urandom) & 6'b001111;
      if (sr < 3) st[5:4] = 2'b11;
      else if (sr == 3) st[5:4] = 2'b01;
      else if (sr == 4) st[5:4] = 2'b10;
      cyc(mk(op, 1'($urandom), 1'($urandom), 5'($urandom), rnd64()), st,
          ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0), rnd64());
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem1_stage.md
Name: mem1_stage

Overview:
- First memory stage of the in-order RV64 pipeline. Sits directly downstream of the execute stage and holds the EX/MEM1 pipeline register.
- Consumes the execute bus, receives load data from the synchronous data SRAM one cycle after the execute stage issues the access, and aligns and sign/zero-extends that data.
- Produces the MEM1→WB bus and a forwarding bus to decode.
- Contains a load-data capture buffer so SRAM data survives downstream stalls.

Parameters:
- EX2MEM1_WD, 182, width of ex2mem1_bus.
- MEM12WB_WD, 166, width of mem12wb_bus.
- MEM12ID_WD, 70, width of mem12id_fwd.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  pipeline flush.
- stall  in  6  stall vector; stall[4] holds the EX/MEM1 boundary, stall[5] holds MEM1/WB.
- ex2mem1_bus  in  182  {lsu_op[6:0], data_ram_sel[7:0], sel_load, rf_we, rf_waddr[4:0], ex_result[63:0], pc[63:0], inst[31:0]}, MSB first.
- data_sram_rdata  in  64  SRAM read data; valid only in the first cycle a load occupies MEM1.
- mem12wb_bus  out  166  {rf_we, rf_waddr[4:0], rf_wdata[63:0], pc[63:0], inst[31:0]}.
- mem12id_fwd  out  70  {rf_we, rf_waddr[4:0], rf_wdata[63:0]}.

Behaviour:
- Pipeline register r (EX2MEM1_WD bits) updates at posedge clk. First matching row wins:
  - rst → 0.
  - flush → 0.
  - stall[4] & !stall[5] → 0 (bubble).
  - !stall[4] → ex2mem1_bus.
  - otherwise hold.
- A bubble is all-zero, so rf_we=0 and no writeback occurs.
- Hold condition hold = stall[4] & stall[5] & !flush.
- lsu_op one-hot, bit 6..0 = {lb, lh, lw, ld, lbu, lhu, lwu}. Stores carry lsu_op=0 (handled upstream).
- Capture buffer: rbuf[63:0] and rbuf_v.
  - On rst, flush, or any cycle r loads or bubbles: rbuf_v → 0 next cycle.
  - If hold & !rbuf_v: rbuf ← data_sram_rdata, rbuf_v ← 1.
  - If hold & rbuf_v: both hold.
- Effective raw data: raw = rbuf_v ? rbuf : data_sram_rdata.
- Result is combinational from r and raw, i.e. valid the same cycle the instruction sits in MEM1.
- Load alignment: off = ex_result[2:0].
  - lb/lbu: byte raw[8*off+7 : 8*off].
  - lh/lhu: half at off[2:1].
  - lw/lwu: word at off[2].
  - ld: raw.
  - Sign-extend lb/lh/lw; zero-extend lbu/lhu/lwu.
- Misaligned halves/words use the truncated lane select (off[0], resp. off[1:0], ignored). Alignment exceptions are raised upstream.
- rf_wdata = sel_load ? aligned_load : ex_result. lsu_op=0 with sel_load=1 yields 0.
- mem12wb_bus and mem12id_fwd are combinational from r and rf_wdata. Both are all-zero data and rf_we=0 after reset and during a bubble.
- rf_waddr=0 is passed through unchanged; decode ignores x0 writes.
- Simultaneous flush and stall: flush wins, register → 0, rbuf_v → 0.
- Reset mid-hold: next cycle all state 0, outputs 0.
- No stall request is generated; the SRAM has fixed one-cycle read latency.
- Latency: one register stage (ex2mem1_bus accepted at edge N appears on outputs during cycle N+1).

Test Plan:
- Reset: assert rst 2 cycles with random inputs → mem12wb_bus=0, mem12id_fwd=0, rbuf_v=0.
- Sign-extended byte load: lb, ex_result=...03, rdata=0x0000_0000_8000_0000 → rf_wdata=0xFFFF_FFFF_FFFF_FF80. Same with lbu → 0x0000_0000_0000_0080.
- Word loads: lw at off=4, rdata=0x8765_4321_0000_0000 → 0xFFFF_FFFF_8765_4321. lwu → 0x0000_0000_8765_4321. ld → rdata unchanged.
- Hold: lh at off=2 with rdata=0x0000_0000_ABCD_0000; hold 3 cycles while rdata changes randomly → rf_wdata=0xFFFF_FFFF_FFFF_ABCD every cycle. Release → next instruction enters, rbuf_v=0.
- Bubble and flush: stall=6'b010000 → next cycle rf_we=0, bus 0. Assert flush during hold → next cycle bus 0, rbuf_v=0.
- Non-load passthrough: sel_load=0, rf_we=1, waddr=5, ex_result=0x1234 → mem12id_fwd={1,5,0x1234} one cycle after acceptance.
